// File: rtl/sram_uart_dump_pkg.sv
// Shared types and constants for the SRAM-to-UART dump path.
//   dump_state_e : word/byte sequencing states of the top FSM
//   tx_state_e   : serialiser states of uart_tx_byte
//   UART_*       : 8N1 frame shape
package sram_uart_dump_pkg;

    localparam int unsigned ADDR_W = 18;
    localparam int unsigned DATA_W = 16;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned UART_STOP_BITS = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_TX_HI,
        S_TX_LO,
        S_NEXT,
        S_DONE
    } dump_state_e;

    typedef enum logic [1:0] {
        S_TX_IDLE,
        S_TX_START,
        S_TX_DATA,
        S_TX_STOP
    } tx_state_e;

endpackage

// File: rtl/sram_uart_dump_tx.sv
// uart_tx_byte: serialises one byte as an 8N1 frame, each bit CLKS_PER_BIT cycles.
//   Clock, Resetn : clock, asynchronous active-low reset
//   Tx_start      : request; accepted when idle or in the last cycle of the stop bit
//   Tx_data       : byte sampled on an accepted Tx_start
//   Tx_busy       : a frame is in progress
//   Tx_done       : high during the last cycle of the final stop bit
//   UART_TX_O     : registered serial line, idle high
module uart_tx_byte
    import sram_uart_dump_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Tx_start,
    input  logic [7:0] Tx_data,
    output logic       Tx_busy,
    output logic       Tx_done,
    output logic       UART_TX_O
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0] LAST_DATA_IDX = 4'(UART_DATA_BITS);
    localparam logic [3:0] LAST_STOP_IDX = 4'(UART_DATA_BITS + UART_STOP_BITS);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             line_q, line_d;
    logic             bit_end;
    logic             accept;

    assign bit_end   = (cnt_q == CNT_LAST);
    assign Tx_done   = (state_q == S_TX_STOP) && bit_end && (bit_idx_q == LAST_STOP_IDX);
    // Accepting in the final stop cycle lets the next start bit follow with no idle gap.
    assign accept    = Tx_start && ((state_q == S_TX_IDLE) || Tx_done);
    assign Tx_busy   = (state_q != S_TX_IDLE);
    assign UART_TX_O = line_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        line_d    = line_q;

        if (state_q != S_TX_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            S_TX_IDLE: begin
            end
            S_TX_START: begin
                if (bit_end) begin
                    state_d   = S_TX_DATA;
                    line_d    = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_idx_d = 4'd1;
                end
            end
            S_TX_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == LAST_DATA_IDX) begin
                        state_d = S_TX_STOP;
                        line_d  = 1'b1;
                    end else begin
                        line_d  = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                    bit_idx_d = bit_idx_q + 4'd1;
                end
            end
            S_TX_STOP: begin
                if (bit_end) begin
                    if (bit_idx_q == LAST_STOP_IDX) begin
                        state_d   = S_TX_IDLE;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            default: state_d = S_TX_IDLE;
        endcase

        if (accept) begin
            state_d   = S_TX_START;
            cnt_d     = '0;
            bit_idx_d = '0;
            shift_d   = Tx_data;
            line_d    = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= S_TX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            line_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            line_q    <= line_d;
        end
    end

endmodule

// File: rtl/sram_uart_dump.sv
// sram_uart_dump: reads Num_words 16-bit words from SRAM starting at Start_address and sends
// each over UART 8N1, high byte first.
//   Clock, Resetn    : clock, asynchronous active-low reset
//   Start            : 1-cycle pulse, honoured only in S_IDLE
//   Start_address    : first word address (wraps at 18 bits)
//   Num_words        : word count, 0 gives an immediate Done with no traffic
//   SRAM_address     : registered word address
//   SRAM_read_data   : read data, valid SRAM_READ_LATENCY cycles after the address
//   SRAM_we_n        : tied high, this block only reads
//   UART_TX_O        : serial output, idle high
//   Busy             : transfer in progress
//   Done             : 1-cycle pulse after the final stop bit
module sram_uart_dump
    import sram_uart_dump_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT      = 434,
    parameter int unsigned SRAM_READ_LATENCY = 2
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Start_address,
    input  logic [ADDR_W-1:0] Num_words,
    output logic [ADDR_W-1:0] SRAM_address,
    input  logic [DATA_W-1:0] SRAM_read_data,
    output logic              SRAM_we_n,
    output logic              UART_TX_O,
    output logic              Busy,
    output logic              Done
);

    localparam int unsigned WAIT_W = (SRAM_READ_LATENCY > 1) ? $clog2(SRAM_READ_LATENCY) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SRAM_READ_LATENCY - 1);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] words_q, words_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_done;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Tx_start (tx_start),
        .Tx_data  (tx_data),
        .Tx_busy  (tx_busy),
        .Tx_done  (tx_done),
        .UART_TX_O(UART_TX_O)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        words_d  = words_q;
        word_d   = word_q;
        wait_d   = wait_q;
        tx_start = 1'b0;
        tx_data  = word_q[7:0];

        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (Num_words != '0) begin
                        state_d = S_READ;
                        addr_d  = Start_address;
                        words_d = Num_words;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_READ: begin
                state_d = S_WAIT;
                wait_d  = '0;
            end
            S_WAIT: begin
                // The high byte goes straight from the bus so its start bit is not delayed
                // by the holding register; the low byte is sent from the latched copy.
                if (wait_q == WAIT_LAST) begin
                    if (!tx_busy) begin
                        word_d   = SRAM_read_data;
                        tx_start = 1'b1;
                        tx_data  = SRAM_read_data[15:8];
                        state_d  = S_TX_HI;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_TX_HI: begin
                if (tx_done) begin
                    tx_start = 1'b1;
                    tx_data  = word_q[7:0];
                    state_d  = S_TX_LO;
                end
            end
            S_TX_LO: begin
                if (tx_done) begin
                    // Last word skips S_NEXT so Done lands right after the final stop bit.
                    if (words_q == {{(ADDR_W-1){1'b0}}, 1'b1}) begin
                        words_d = '0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                addr_d  = addr_q + 1'b1;
                words_d = words_q - 1'b1;
                state_d = S_READ;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            words_q <= '0;
            word_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            word_q  <= word_d;
            wait_q  <= wait_d;
        end
    end

    assign SRAM_address = addr_q;
    assign SRAM_we_n    = 1'b1;
    assign Busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign Done         = (state_q == S_DONE);

endmodule

// File: tb/tb_sram_uart_dump.sv
module tb_sram_uart_dump;

    localparam int CPB      = 4;
    localparam int LAT      = 2;
    localparam int FRAME    = 10 * CPB;
    localparam int WORD_GAP = 2 + LAT;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [17:0] start_address = '0;
    logic [17:0] num_words = '0;
    logic [17:0] sram_address;
    logic [15:0] sram_read_data;
    logic        sram_we_n;
    logic        uart_tx_o;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    sram_uart_dump #(
        .CLKS_PER_BIT     (CPB),
        .SRAM_READ_LATENCY(LAT)
    ) dut (
        .Clock         (clock),
        .Resetn        (resetn),
        .Start         (start),
        .Start_address (start_address),
        .Num_words     (num_words),
        .SRAM_address  (sram_address),
        .SRAM_read_data(sram_read_data),
        .SRAM_we_n     (sram_we_n),
        .UART_TX_O     (uart_tx_o),
        .Busy          (busy),
        .Done          (done)
    );

    always #5 clock = ~clock;

    // SRAM emulator: data for the address seen in cycle r is on the bus in cycle r+2.
    logic [15:0] sram_mem [0:262143];
    logic [15:0] rd1 = '0;
    logic [15:0] rd2 = '0;
    assign sram_read_data = rd2;

    always @(posedge clock) begin
        rd1 <= sram_mem[sram_address];
        rd2 <= rd1;
        cyc <= cyc + 1;
    end

    // Observers, sampled 1 time unit after each rising edge.
    logic [7:0]  rx_q[$];
    int          rx_t[$];
    logic [17:0] addr_log[$];
    int          frame_err = 0;
    int          we_low = 0;
    int          done_total = 0;
    bit          mon_active = 0;
    int          mon_off = 0;
    int          mon_t0 = 0;
    logic [9:0]  mon_bits = '0;

    always @(posedge clock) begin
        #1;
        if (sram_we_n !== 1'b1) we_low++;
        if (done === 1'b1) done_total++;
        if (busy === 1'b1 && (addr_log.size() == 0 || addr_log[addr_log.size()-1] !== sram_address))
            addr_log.push_back(sram_address);
        if (resetn !== 1'b1) begin
            mon_active = 0;
        end else begin
            if (!mon_active && uart_tx_o === 1'b0) begin
                mon_active = 1;
                mon_off    = 0;
                mon_t0     = cyc;
            end
            if (mon_active) begin
                if (mon_off % CPB == 0) mon_bits[mon_off/CPB] = uart_tx_o;
                else if (uart_tx_o !== mon_bits[mon_off/CPB]) frame_err++;
                mon_off++;
                if (mon_off == FRAME) begin
                    mon_active = 0;
                    if (mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) frame_err++;
                    rx_q.push_back(mon_bits[8:1]);
                    rx_t.push_back(mon_t0);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=time limit reached required=bench finishes");
        $fatal(1, "watchdog");
    end

    // Runs one transfer and checks bytes, frame timing, Done/Busy and addresses against a model
    // built from the memory contents: word i is at (a+i) mod 2^18, high byte then low byte.
    task automatic run_transfer(input string name, input logic [17:0] a, input int n,
                                input bit extra_start, input bit start_on_done);
        logic [7:0]  exp_b[$];
        logic [17:0] exp_a[$];
        int s, d, busy_bad, idle_bad, done_before, budget, gap;
        for (int i = 0; i < n; i++) begin
            logic [17:0] ai;
            logic [15:0] w;
            ai = a + 18'(i);
            w  = sram_mem[ai];
            exp_b.push_back(w[15:8]);
            exp_b.push_back(w[7:0]);
            exp_a.push_back(ai);
        end
        rx_q.delete();
        rx_t.delete();
        addr_log.delete();
        frame_err   = 0;
        we_low      = 0;
        done_before = done_total;

        @(negedge clock);
        start = 1'b1; start_address = a; num_words = 18'(n); s = cyc;
        @(negedge clock);
        start = 1'b0; start_address = 18'($urandom); num_words = 18'($urandom);

        d = -1; busy_bad = 0;
        budget = 100 + n * (2 * FRAME + WORD_GAP + 10);
        for (int k = 0; k < budget; k++) begin
            if (done === 1'b1) begin
                d = cyc;
                break;
            end
            if (busy !== ((n != 0) ? 1'b1 : 1'b0)) busy_bad++;
            if (extra_start && cyc == s + FRAME + 7) begin
                start = 1'b1; start_address = a + 18'd5; num_words = 18'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
        end

        checks++;
        if (d < 0) begin
            failures++;
            $display("FAIL %s done_timeout: actual=no Done required=Done within %0d cycles",
                     name, budget);
            start = 1'b0;
        end else begin
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL %s busy_at_done: actual=%b required=0", name, busy);
            end
            if (n == 0) begin
                checks++;
                if (d != s + 1) begin
                    failures++;
                    $display("FAIL %s zero_done_latency: actual=%0d required=1", name, d - s);
                end
            end
            if (start_on_done) begin
                start = 1'b1; start_address = 18'($urandom);
                num_words = 18'($urandom_range(1, 3));
            end
            @(negedge clock);
            start = 1'b0;
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL %s done_single_pulse: actual=%b required=0", name, done);
            end
        end

        idle_bad = 0;
        for (int k = 0; k < 8; k++) begin
            if (busy !== 1'b0 || uart_tx_o !== 1'b1) idle_bad++;
            @(negedge clock);
        end
        checks++;
        if (idle_bad != 0) begin
            failures++;
            $display("FAIL %s idle_after_done: actual=%0d busy/line cycles required=0", name, idle_bad);
        end

        checks++;
        if (busy_bad != 0) begin
            failures++;
            $display("FAIL %s busy_during: actual=%0d bad cycles required=0", name, busy_bad);
        end
        checks++;
        if (done_total - done_before != 1) begin
            failures++;
            $display("FAIL %s done_count: actual=%0d required=1", name, done_total - done_before);
        end
        checks++;
        if (rx_q.size() != exp_b.size()) begin
            failures++;
            $display("FAIL %s byte_count: actual=%0d required=%0d", name, rx_q.size(), exp_b.size());
        end else begin
            for (int j = 0; j < exp_b.size(); j++) begin
                checks++;
                if (rx_q[j] !== exp_b[j]) begin
                    failures++;
                    $display("FAIL %s byte[%0d]: actual=%02h required=%02h", name, j, rx_q[j], exp_b[j]);
                end
            end
            for (int j = 1; j < rx_t.size(); j++) begin
                gap = (j % 2 == 1) ? FRAME : FRAME + WORD_GAP;
                checks++;
                if (rx_t[j] - rx_t[j-1] != gap) begin
                    failures++;
                    $display("FAIL %s start_spacing[%0d]: actual=%0d required=%0d", name, j,
                             rx_t[j] - rx_t[j-1], gap);
                end
            end
            if (rx_t.size() > 0 && d >= 0) begin
                checks++;
                if (d != rx_t[rx_t.size()-1] + FRAME) begin
                    failures++;
                    $display("FAIL %s done_timing: actual=%0d required=%0d", name,
                             d - rx_t[rx_t.size()-1], FRAME);
                end
            end
        end
        checks++;
        if (addr_log != exp_a) begin
            failures++;
            $display("FAIL %s addresses: actual=%p required=%p", name, addr_log, exp_a);
        end
        checks++;
        if (frame_err != 0 || we_low != 0) begin
            failures++;
            $display("FAIL %s frame_or_we: actual=frame_err %0d we_low %0d required=0 0", name,
                     frame_err, we_low);
        end
    endtask

    task automatic test_reset();
        start = 1'b1; start_address = 18'h00123; num_words = 18'd3;
        repeat (3) @(negedge clock);
        checks++;
        if (uart_tx_o !== 1'b1) begin
            failures++; $display("FAIL reset_line: actual=%b required=1", uart_tx_o);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy: actual=%b required=0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            failures++; $display("FAIL reset_done: actual=%b required=0", done);
        end
        checks++;
        if (sram_we_n !== 1'b1) begin
            failures++; $display("FAIL reset_we_n: actual=%b required=1", sram_we_n);
        end
        checks++;
        if (sram_address !== 18'h0) begin
            failures++; $display("FAIL reset_address: actual=%05h required=00000", sram_address);
        end
        start = 1'b0;
        resetn = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_single_word();
        sram_mem[18'h00100] = 16'hA55A;
        run_transfer("single_word", 18'h00100, 1, 1'b0, 1'b0);
    endtask

    task automatic test_four_words_with_extra_start();
        sram_mem[0] = 16'h0001;
        sram_mem[1] = 16'h0203;
        sram_mem[2] = 16'h0405;
        sram_mem[3] = 16'h0607;
        sram_mem[5] = 16'hFFFF;
        run_transfer("four_words", 18'h00000, 4, 1'b1, 1'b0);
    endtask

    task automatic test_wrap();
        sram_mem[18'h3FFFF] = 16'hBEEF;
        sram_mem[18'h00000] = 16'hCAFE;
        run_transfer("wrap", 18'h3FFFF, 2, 1'b0, 1'b1);
    endtask

    task automatic test_zero_words();
        run_transfer("zero_words", 18'h01234, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            logic [17:0] a;
            int n;
            a = ($urandom_range(0, 1) == 1) ? 18'h3FFFF - 18'($urandom_range(0, 3))
                                            : 18'($urandom);
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) sram_mem[a + 18'(i)] = 16'($urandom);
            run_transfer("random", a, n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid();
        bit hit;
        int dt0;
        for (int i = 0; i < 4; i++) sram_mem[18'h02000 + 18'(i)] = 16'($urandom);
        rx_q.delete();
        rx_t.delete();
        @(negedge clock);
        start = 1'b1; start_address = 18'h02000; num_words = 18'd4;
        @(negedge clock);
        start = 1'b0;
        hit = 0;
        for (int k = 0; k < 2000; k++) begin
            if (rx_q.size() == 2 && mon_active && mon_off >= CPB + 2) begin
                hit = 1;
                break;
            end
            @(negedge clock);
        end
        checks++;
        if (!hit) begin
            failures++; $display("FAIL reset_mid_reach: actual=third byte not seen required=seen");
        end
        dt0 = done_total;
        resetn = 1'b0;
        #1;
        checks++;
        if (uart_tx_o !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || sram_address !== 18'h0) begin
            failures++;
            $display("FAIL reset_mid_outputs: actual=line %b busy %b done %b addr %05h required=1 0 0 00000",
                     uart_tx_o, busy, done, sram_address);
        end
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        repeat (6) @(negedge clock);
        checks++;
        if (done_total != dt0 || rx_q.size() != 2 || mon_active || uart_tx_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_quiet: actual=done %0d bytes %0d active %0d required=0 2 0",
                     done_total - dt0, rx_q.size(), mon_active);
        end
        for (int i = 0; i < 3; i++) sram_mem[18'h04000 + 18'(i)] = 16'($urandom);
        run_transfer("after_reset", 18'h04000, 3, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_four_words_with_extra_start();
        test_wrap();
        test_zero_words();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
